uncache_unit: RTL and testbench
===============================

# uncache_unit

Uncached data-access engine sitting directly downstream of the fixed-mapping address translator. It takes the CPU data request with the translated physical address and `cache_v` flag, ignores cached requests (the D-cache owns them), and turns uncached loads and stores into single-beat bus transactions toward the AXI bridge. Stores are posted through a one-entry write buffer; loads stall the pipeline until data returns and always drain the write buffer first.

## Interface
Parameters:
- `AW`, 32, physical address width
- `DW`, 32, data width; strobe width is `DW/8`

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `data_en`  in  1  CPU data request valid; held stable by the CPU while `stallreq`=1
- `data_wen`  in  4  byte write strobes; 0 = load
- `data_paddr`  in  AW  physical address from translator
- `data_cache_v`  in  1  1 = cached (ignored here), 0 = uncached
- `data_wdata`  in  DW  store data
- `data_rdata`  out  DW  load result, registered
- `stallreq`  out  1  pipeline stall request
- `rd_req`  out  1  read request valid
- `rd_addr`  out  AW  read address
- `rd_rdy`  in  1  read request accepted
- `ret_valid`  in  1  read data valid
- `ret_data`  in  DW  read data
- `wr_req`  out  1  write request valid
- `wr_addr`  out  AW  write address
- `wr_wstrb`  out  4  write strobes
- `wr_data`  out  DW  write data
- `wr_rdy`  in  1  write request accepted
- `wr_done`  in  1  write response received

## Operation
- Request is uncached (`ureq`) when `data_en & ~data_cache_v`. With `data_cache_v`=1 the block contributes `stallreq`=0 and starts nothing.
- Write buffer FSM `W_EMPTY -> W_REQ -> W_WAIT -> W_EMPTY`:
  - W_EMPTY: uncached store (`data_wen`!=0) with read FSM in R_IDLE is captured (addr, wstrb, wdata) this cycle, `stallreq`=0, next state W_REQ.
  - W_REQ: `wr_req`=1 with buffered fields; on `wr_rdy` go to W_WAIT.
  - W_WAIT: on `wr_done` go to W_EMPTY.
  - A store arriving while state != W_EMPTY: `stallreq`=1; captured in the first cycle the state is W_EMPTY.
- Read FSM `R_IDLE -> R_REQ -> R_WAIT -> R_DONE -> R_IDLE`:
  - R_IDLE: uncached load waits (`stallreq`=1) while the write buffer is not W_EMPTY; once empty, latch `data_paddr` into `rd_addr`, go to R_REQ, `stallreq`=1.
  - R_REQ: `rd_req`=1; on `rd_rdy` go to R_WAIT.
  - R_WAIT: on `ret_valid` register `ret_data` into `data_rdata`, go to R_DONE.
  - R_DONE: `stallreq`=0 for exactly this cycle (load retires); unconditional return to R_IDLE. A load still presented in R_DONE is not reissued.
- `stallreq` = `ureq` & ~(store accepted this cycle) & ~(read FSM in R_DONE).
- `data_rdata` holds until the next load completes.
- No ordering with cached accesses is enforced here.

## Timing
- Reset: all FSMs to W_EMPTY/R_IDLE; `rd_req`, `wr_req`, `data_rdata`, `rd_addr`, `wr_addr`, `wr_wstrb`, `wr_data` = 0; `stallreq`=0 while `rst`=1.
- Store, buffer empty: zero stall cycles; `wr_req` rises the cycle after acceptance.
- Load, buffer empty, `rd_rdy` and `ret_valid` immediate: stall cycles 0-2, `rd_req` in cycle 1, `ret_valid` in cycle 2, `data_rdata` valid and `stallreq`=0 in cycle 3.
- `wr_done` and a new store in the same cycle: store stalls one cycle and is accepted the next.
- `rd_req`/`wr_req` stay asserted, fields stable, until accepted.
- Reset mid-transaction abandons it; the bus side shares `rst`.

## Test plan
- Uncached store 0xBFAF_F000 -> paddr 0x1FAF_F000, wen=4'hF, wdata 0x1234_5678 -> `stallreq`=0, next cycle `wr_req`=1 with same fields; `wr_rdy`, then `wr_done` -> buffer empty.
- Back-to-back stores, `wr_done` delayed 5 cycles -> second store stalls until the cycle after `wr_done`, then captured with its own data.
- Uncached load, immediate `rd_rdy`/`ret_valid` with 0xDEAD_BEEF -> 3 stall cycles, `data_rdata`=0xDEAD_BEEF in cycle 3, no second `rd_req`.
- Store followed by load while `wr_done` pending -> `rd_req` not asserted before the cycle after `wr_done`.
- Cached request (`data_cache_v`=1) -> `stallreq`=0, no `rd_req`/`wr_req` ever.
- `rst` asserted in R_WAIT -> next cycle all outputs 0, FSMs idle; fresh load then completes normally.

Source files
------------

// File: rtl/uncache_unit.sv
// Uncached load/store engine: filters out cached requests and turns uncached
// loads and stores into single-beat bus transactions. Stores are posted
// through a one-entry write buffer; loads drain that buffer first and stall
// the pipeline until their data has been returned and registered.
module uncache_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_en,
  input  logic [DW/8-1:0]   data_wen,
  input  logic [AW-1:0]     data_paddr,
  input  logic              data_cache_v,
  input  logic [DW-1:0]     data_wdata,
  output logic [DW-1:0]     data_rdata,
  output logic              stallreq,
  output logic              rd_req,
  output logic [AW-1:0]     rd_addr,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic [DW-1:0]     ret_data,
  output logic              wr_req,
  output logic [AW-1:0]     wr_addr,
  output logic [DW/8-1:0]   wr_wstrb,
  output logic [DW-1:0]     wr_data,
  input  logic              wr_rdy,
  input  logic              wr_done
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    W_EMPTY = 2'd0,
    W_REQ   = 2'd1,
    W_WAIT  = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2,
    R_DONE = 2'd3
  } r_state_e;

  w_state_e w_state_r;
  w_state_e w_next_s;
  r_state_e r_state_r;
  r_state_e r_next_s;

  logic ureq_s;
  logic store_s;
  logic load_s;
  logic store_acc_s;
  logic load_acc_s;

  // Request classification, acceptance conditions and the pipeline stall.
  // A load or store is only taken while both engines are quiet, which keeps
  // loads ordered behind any posted store.
  always_comb begin
    ureq_s      = data_en & ~data_cache_v;
    store_s     = ureq_s & (data_wen != {SW{1'b0}});
    load_s      = ureq_s & (data_wen == {SW{1'b0}});
    store_acc_s = store_s & (w_state_r == W_EMPTY) & (r_state_r == R_IDLE);
    load_acc_s  = load_s & (w_state_r == W_EMPTY) & (r_state_r == R_IDLE);
    stallreq    = ~rst & ureq_s & ~store_acc_s & (r_state_r != R_DONE);
  end

  // Write buffer next-state: capture, request until accepted, await response.
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_EMPTY: begin
        if (store_acc_s) w_next_s = W_REQ;
        else             w_next_s = W_EMPTY;
      end
      W_REQ: begin
        if (wr_rdy) w_next_s = W_WAIT;
        else        w_next_s = W_REQ;
      end
      W_WAIT: begin
        if (wr_done) w_next_s = W_EMPTY;
        else         w_next_s = W_WAIT;
      end
      default: w_next_s = W_EMPTY;
    endcase
  end

  // Read next-state: R_DONE is the single retire cycle and always returns to
  // idle, so a load still held by the CPU there is not reissued.
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (load_acc_s) r_next_s = R_REQ;
        else            r_next_s = R_IDLE;
      end
      R_REQ: begin
        if (rd_rdy) r_next_s = R_WAIT;
        else        r_next_s = R_REQ;
      end
      R_WAIT: begin
        if (ret_valid) r_next_s = R_DONE;
        else           r_next_s = R_WAIT;
      end
      R_DONE:  r_next_s = R_IDLE;
      default: r_next_s = R_IDLE;
    endcase
  end

  // State registers and request strobes, registered from the next state so
  // that requests rise the cycle after capture and drop right after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_r <= W_EMPTY;
      r_state_r <= R_IDLE;
      wr_req    <= 1'b0;
      rd_req    <= 1'b0;
    end else begin
      w_state_r <= w_next_s;
      r_state_r <= r_next_s;
      wr_req    <= (w_next_s == W_REQ);
      rd_req    <= (r_next_s == R_REQ);
    end
  end

  // Datapath: buffered store fields, latched load address, load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr    <= {AW{1'b0}};
      wr_wstrb   <= {SW{1'b0}};
      wr_data    <= {DW{1'b0}};
      rd_addr    <= {AW{1'b0}};
      data_rdata <= {DW{1'b0}};
    end else begin
      if (store_acc_s) begin
        wr_addr  <= data_paddr;
        wr_wstrb <= data_wen;
        wr_data  <= data_wdata;
      end
      if (load_acc_s) begin
        rd_addr <= data_paddr;
      end
      if ((r_state_r == R_WAIT) && ret_valid) begin
        data_rdata <= ret_data;
      end
    end
  end

endmodule

// File: tb/tb_uncache_unit.sv
// Bench for uncache_unit: a CPU-side driver issues loads/stores and records
// expected bus transactions and load results from a program-order memory
// model; a bus responder keeps its own memory fed only by DUT writes; a
// monitor pops expectations as the DUT presents transactions and retires.
module tb_uncache_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_en = 1'b0;
  logic [3:0]  data_wen = 4'h0;
  logic [31:0] data_paddr = 32'h0;
  logic        data_cache_v = 1'b0;
  logic [31:0] data_wdata = 32'h0;
  logic [31:0] data_rdata;
  logic        stallreq;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_rdy = 1'b0;
  logic        ret_valid = 1'b0;
  logic [31:0] ret_data = 32'h0;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [3:0]  wr_wstrb;
  logic [31:0] wr_data;
  logic        wr_rdy = 1'b0;
  logic        wr_done = 1'b0;

  uncache_unit #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .data_en(data_en), .data_wen(data_wen), .data_paddr(data_paddr),
    .data_cache_v(data_cache_v), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .stallreq(stallreq),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [31:0] exp_rd_addr_q[$];
  logic [31:0] exp_rdata_q[$];

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];

  int n_checks = 0;
  int n_pass = 0;
  int n_stores = 0;
  int n_loads = 0;
  int n_wr_done = 0;
  int last_done_cyc = -10;
  int rd_hs = 0;
  int wr_hs = 0;

  bit bus_rand = 1'b0;
  int wdone_dly = 0;
  int ret_dly = 0;
  bit ret_hold = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    else return init_val(a);
  endfunction

  function automatic logic [31:0] bus_read(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    else return init_val(a);
  endfunction

  // Bus write side: accept requests, update bus memory, respond with wr_done.
  bit          w_pend = 1'b0;
  bit          w_busy = 1'b0;
  int          w_timer = 0;
  wr_t         wl;
  always begin
    @(posedge clk); #1;
    wr_done = 1'b0;
    wr_rdy  = 1'b0;
    if (rst) begin
      w_pend = 1'b0;
      w_busy = 1'b0;
    end else begin
      if (w_pend) begin
        w_pend = 1'b0;
        bus_mem[wl.addr] = merge(bus_read(wl.addr), wl.data, wl.strb);
        w_busy  = 1'b1;
        w_timer = bus_rand ? int'($urandom_range(0, 4)) : wdone_dly;
      end
      if (w_busy) begin
        if (w_timer == 0) begin
          wr_done = 1'b1;
          w_busy = 1'b0;
          n_wr_done++;
          last_done_cyc = cyc;
        end else w_timer--;
      end
      if (wr_req && (!bus_rand || $urandom_range(0, 2) != 0)) begin
        wr_rdy = 1'b1;
        w_pend = 1'b1;
        wl.addr = wr_addr;
        wl.strb = wr_wstrb;
        wl.data = wr_data;
      end
    end
  end

  // Bus read side: accept requests and return bus memory contents.
  bit          r_pend = 1'b0;
  bit          r_busy = 1'b0;
  int          r_timer = 0;
  logic [31:0] rl_addr = 32'h0;
  always begin
    @(posedge clk); #1;
    ret_valid = 1'b0;
    rd_rdy    = 1'b0;
    if (rst) begin
      r_pend = 1'b0;
      r_busy = 1'b0;
    end else begin
      if (r_pend) begin
        r_pend  = 1'b0;
        r_busy  = 1'b1;
        r_timer = ret_hold ? 1000000 : (bus_rand ? int'($urandom_range(0, 4)) : ret_dly);
      end
      if (r_busy) begin
        if (r_timer == 0) begin
          ret_valid = 1'b1;
          ret_data  = bus_read(rl_addr);
          r_busy    = 1'b0;
        end else r_timer--;
      end
      if (rd_req && (!bus_rand || $urandom_range(0, 2) != 0)) begin
        rd_rdy  = 1'b1;
        r_pend  = 1'b1;
        rl_addr = rd_addr;
      end
    end
  end

  // Monitor: compare bus transactions and retired loads against expectations.
  bit  rd_req_prev = 1'b0;
  wr_t me;
  logic [31:0] mv;
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_req && wr_rdy) begin
        wr_hs++;
        if (exp_wr_q.size() == 0) chk("unexpected_wr", 1, 0);
        else begin
          me = exp_wr_q.pop_front();
          chk("wr_addr", wr_addr, me.addr);
          chk("wr_wstrb", wr_wstrb, me.strb);
          chk("wr_data", wr_data, me.data);
        end
      end
      if (rd_req && rd_rdy) begin
        rd_hs++;
        if (exp_rd_addr_q.size() == 0) chk("unexpected_rd", 1, 0);
        else begin
          mv = exp_rd_addr_q.pop_front();
          chk("rd_addr", rd_addr, mv);
        end
      end
      if (rd_req && !rd_req_prev)
        chk("rd_after_drain", ((n_stores - n_wr_done) == 0) && (cyc >= last_done_cyc + 2), 1);
      if (data_en && data_cache_v) chk("cached_nostall", stallreq, 0);
      if (data_en && !data_cache_v && data_wen == 4'h0 && !stallreq) begin
        if (exp_rdata_q.size() == 0) chk("unexpected_retire", 1, 0);
        else begin
          mv = exp_rdata_q.pop_front();
          chk("load_rdata", data_rdata, mv);
        end
      end
    end
    rd_req_prev = rd_req;
  end

  task automatic idle(input int n);
    data_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request and hold it until the DUT drops stallreq.
  task automatic do_op(input bit cached, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, output int stalls, output int acc_cyc);
    bit  retired;
    bit  is_store;
    wr_t e;
    is_store     = (wen != 4'h0);
    data_en      = 1'b1;
    data_cache_v = cached;
    data_wen     = wen;
    data_paddr   = addr;
    data_wdata   = wdata;
    if (!cached) begin
      if (is_store) begin
        e.addr = addr; e.strb = wen; e.data = wdata;
        exp_wr_q.push_back(e);
        ref_mem[addr] = merge(ref_read(addr), wdata, wen);
      end else begin
        exp_rd_addr_q.push_back(addr);
        exp_rdata_q.push_back(ref_read(addr));
      end
    end
    stalls = 0; retired = 1'b0; acc_cyc = -1;
    while (!retired && stalls <= 200) begin
      @(negedge clk);
      if (!stallreq) begin retired = 1'b1; acc_cyc = cyc; end
      else stalls++;
    end
    if (!retired) chk("retire_timeout", 0, 1);
    else if (!cached) begin
      if (is_store) n_stores++;
      else n_loads++;
    end
    @(posedge clk); #1;
    data_en = 1'b0;
  endtask

  task automatic chk_outputs_zero();
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_wstrb", wr_wstrb, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_stallreq", stallreq, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int st, ac, ac2, wait_n;
    logic [31:0] a, d;
    logic [3:0]  w;
    int k;

    // Reset: an uncached load presented during reset must not stall.
    data_en = 1'b1; data_paddr = 32'h1FC0_0040;
    @(negedge clk);
    chk("reset_stall", stallreq, 0);
    @(posedge clk); #1; data_en = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero();
    @(posedge clk); #1;

    // Single store, buffer empty: no stall, wr_req the next cycle.
    do_op(1'b0, 4'hF, 32'h1FAF_F000, 32'h1234_5678, st, ac);
    chk("store_stalls", st, 0);
    @(negedge clk);
    chk("wr_req_next", wr_req, 1);
    @(posedge clk); #1;
    idle(6);

    // Back-to-back stores with wr_done 5 cycles late.
    wdone_dly = 5;
    do_op(1'b0, 4'hF, 32'h1FC0_0008, 32'hAAAA_0001, st, ac);
    do_op(1'b0, 4'h3, 32'h1FC0_000C, 32'hBBBB_0002, st, ac2);
    chk("b2b_accept_cycle", ac2, last_done_cyc + 1);
    idle(12);

    // Load with immediate bus: three stall cycles, retire in the fourth.
    wdone_dly = 0; ret_dly = 0;
    do_op(1'b0, 4'hF, 32'h1FC0_0100, 32'hDEAD_BEEF, st, ac);
    idle(6);
    do_op(1'b0, 4'h0, 32'h1FC0_0100, 32'h0, st, ac);
    chk("load_stalls", st, 3);
    chk("load_deadbeef", data_rdata, 32'hDEAD_BEEF);
    idle(3);
    chk("single_rd_req", rd_hs, n_loads);

    // Store then load while wr_done is pending.
    wdone_dly = 6;
    do_op(1'b0, 4'h5, 32'h1FC0_0100, 32'h0011_2233, st, ac);
    do_op(1'b0, 4'h0, 32'h1FC0_0100, 32'h0, st, ac);
    chk("load_after_store_data", data_rdata, 32'hDE11_BE33);
    idle(4);

    // Cached requests: no stall, no bus traffic.
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 4'($urandom_range(0, 15)), 32'h0000_1000 + 32'(i), $urandom, st, ac);
      chk("cached_stalls", st, 0);
    end
    idle(3);
    chk("cached_no_rd", rd_hs, n_loads);
    chk("cached_no_wr", wr_hs, n_stores);

    // Reset while the read engine waits for data, then a fresh load.
    wdone_dly = 0; ret_hold = 1'b1;
    data_en = 1'b1; data_cache_v = 1'b0; data_wen = 4'h0; data_paddr = 32'h1FC0_0014;
    exp_rd_addr_q.push_back(32'h1FC0_0014);
    exp_rdata_q.push_back(ref_read(32'h1FC0_0014));
    wait_n = 0;
    do begin @(negedge clk); wait_n++; end while (!(rd_req && rd_rdy) && wait_n < 50);
    if (wait_n >= 50) chk("rwait_timeout", 0, 1);
    else n_loads++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_rwait_stall", stallreq, 0);
    @(posedge clk); #1; data_en = 1'b0;
    @(posedge clk); #1; rst = 1'b0; ret_hold = 1'b0;
    exp_rdata_q.delete();
    exp_rd_addr_q.delete();
    @(negedge clk);
    chk_outputs_zero();
    @(posedge clk); #1;
    do_op(1'b0, 4'h0, 32'h1FC0_0100, 32'h0, st, ac);
    chk("post_reset_load_stalls", st, 3);

    // Randomized mix against the program-order memory model.
    bus_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 9);
      a = 32'h1FC0_0000 + (32'($urandom_range(0, 7)) << 2);
      d = $urandom;
      if (k < 2) begin
        w = 4'($urandom_range(0, 15));
        do_op(1'b1, w, a, d, st, ac);
      end else if (k < 6) begin
        w = 4'($urandom_range(1, 15));
        do_op(1'b0, w, a, d, st, ac);
      end else begin
        do_op(1'b0, 4'h0, a, d, st, ac);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(30);
    chk("end_wr_q_empty", exp_wr_q.size(), 0);
    chk("end_rd_q_empty", exp_rd_addr_q.size(), 0);
    chk("end_rdata_q_empty", exp_rdata_q.size(), 0);
    chk("end_rd_count", rd_hs, n_loads);
    chk("end_wr_count", wr_hs, n_stores);
    chk("end_wr_done_count", n_wr_done, n_stores);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
